program_loader: RTL
===================

# program_loader

Upstream feeder for the microprocessor: accepts a byte stream of program instructions over a valid/ready handshake and writes it into the 64-entry instruction memory that the processor reads. It holds the processor in reset while loading and releases it once the program is complete. It supports reloading at run time, and flags programs longer than the memory.

## Interface
- ADDR_WIDTH, 6, instruction address width; matches processor `pc`
- DATA_WIDTH, 8, instruction width
- MEM_SIZE, 2**ADDR_WIDTH, number of instruction words
- FILL_WORD, '0, value written to every unloaded entry

- clk  in  1  system clock, all state on posedge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  request a (re)load; sampled in IDLE and RUN only
- in_valid  in  1  stream byte valid
- in_data  in  DATA_WIDTH  stream byte (one instruction)
- in_last  in  1  marks final byte of program; qualified by in_valid
- in_ready  out  1  loader accepts byte this cycle
- instructions  out  DATA_WIDTH x MEM_SIZE (unpacked [0:MEM_SIZE-1])  instruction memory contents, drives processor
- cpu_rst  out  1  processor reset; high while not in RUN
- load_count  out  ADDR_WIDTH+1  bytes stored by current/last load (0..MEM_SIZE)
- done  out  1  one-cycle pulse on entry to RUN
- overflow_err  out  1  sticky: last load exceeded MEM_SIZE; cleared by next start or rst

## Operation
- States: IDLE, LOAD, DRAIN, RUN (shared enum).
- IDLE: in_ready=0, cpu_rst=1. start=1 -> clear all entries to FILL_WORD, wr_ptr=0, load_count=0, overflow_err=0, -> LOAD (clear happens in the same edge).
- LOAD: in_ready=1. Handshake in_valid&&in_ready writes in_data to instructions[wr_ptr], wr_ptr++, load_count++.
  - Accept with in_last=1 -> RUN (byte is still stored).
  - Accept at wr_ptr=MEM_SIZE-1 with in_last=0 -> byte stored, overflow_err=1, -> DRAIN.
  - start ignored.
- DRAIN: in_ready=1, accepted bytes discarded, memory and load_count unchanged; accept with in_last=1 -> RUN.
- RUN: in_ready=0, cpu_rst=0. start=1 -> same clear/reset actions as IDLE, -> LOAD (cpu_rst=1 from next cycle).
- in_last with in_valid=0 has no effect. Empty program is not possible: first accepted byte with in_last=1 gives load_count=1.
- wr_ptr never wraps; DRAIN prevents overwrite of entry 0.

## Timing
- Reset (async assert, sync to clk on release): state IDLE, all instructions=FILL_WORD, in_ready=0, cpu_rst=1, load_count=0, done=0, overflow_err=0.
- rst mid-LOAD/DRAIN: abort immediately. Partial program is discarded (memory back to FILL_WORD).
- All outputs are registered except in_ready, which is decoded from state only (no combinational path from in_valid).
- Byte accepted at edge N: visible on instructions and load_count after edge N.
- Final byte accepted at edge N: state=RUN, cpu_rst=0, done=1 after edge N. done=0 after edge N+1.
- start in RUN at edge N: cpu_rst=1 and memory cleared after edge N. The processor therefore sees reset before any new byte lands.
- Throughput: one byte per cycle, in LOAD and DRAIN.

## Structure
- Package `microprocessor_pkg`: ADDR_WIDTH, DATA_WIDTH, MEM_SIZE defaults, FILL_WORD, `loader_state_e` typedef (IDLE, LOAD, DRAIN, RUN).
- Single module, no sub-modules. Memory is a flop array so the clear can be done in one cycle. The FSM and the write pointer are in the same module.
- cpu_rst feeds the processor's rst via the top level, ORed with system rst.

## Test plan
- Reset: after rst, all 64 entries=0x00, cpu_rst=1, in_ready=0, load_count=0.
- Basic load: start, then stream 0x11,0x22,0x33 (last on 0x33), valid every cycle. Expect:
  - entries 0..2 = 11/22/33, rest 0x00, load_count=3
  - done pulse 1 cycle, cpu_rst falls the same cycle.
- Backpressure/gaps: the same stream with in_valid toggling 1,0,0,1,0,1. Expect an identical memory image. in_last asserted with in_valid=0 must be ignored.
- Full, exact: 64 bytes 0x00..0x3F, last on 0x3F. Expect entry i = i, load_count=64, overflow_err=0, RUN.
- Overflow: 70 bytes with last on byte 70. Expect:
  - entries 0..63 = first 64 bytes, load_count=64, overflow_err=1
  - 6 bytes drained with in_ready=1
  - RUN after byte 70.
- Reload and reset mid-load: in RUN, start. Expect cpu_rst=1 and memory cleared, then load 0xAA. Then start again, send 2 bytes, assert rst. Expect all entries 0x00, IDLE.

Source files
------------

// File: rtl/microprocessor_pkg.sv
// Shared definitions for the microprocessor instruction path: default geometry
// of the instruction memory and the loader FSM state encoding.
package microprocessor_pkg;

    localparam int ADDR_WIDTH_DFLT = 6;
    localparam int DATA_WIDTH_DFLT = 8;
    localparam int MEM_SIZE_DFLT   = 2 ** ADDR_WIDTH_DFLT;

    localparam logic [DATA_WIDTH_DFLT-1:0] FILL_WORD = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Streams program bytes into the processor's instruction memory, keeping the
// processor in reset until a complete program has landed.
module program_loader
    import microprocessor_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DFLT,
    parameter int                    DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int                    MEM_SIZE   = 2 ** ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] instructions [0:MEM_SIZE-1],
    output logic                  cpu_rst,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  done,
    output logic                  overflow_err
);

    localparam int                CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MEM_SIZE - 1);

    loader_state_e state_q;
    loader_state_e state_d;
    logic          clear;
    logic          wr_en;
    logic          set_ovf;

    // in_ready depends on state only, so there is no path from in_valid.
    assign in_ready = (state_q == LOAD) || (state_q == DRAIN);

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        wr_en   = 1'b0;
        set_ovf = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_last) begin
                        state_d = RUN;
                    end else if (load_count == LAST_IDX) begin
                        set_ovf = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (in_valid && in_last) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The memory is a flop array so a reload can wipe it in a single edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            load_count   <= '0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            for (int i = 0; i < MEM_SIZE; i++) begin
                instructions[i] <= FILL_WORD;
            end
        end else begin
            state_q <= state_d;
            cpu_rst <= (state_d != RUN);
            done    <= (state_d == RUN) && (state_q != RUN);
            if (clear) begin
                load_count   <= '0;
                overflow_err <= 1'b0;
                for (int i = 0; i < MEM_SIZE; i++) begin
                    instructions[i] <= FILL_WORD;
                end
            end else if (wr_en) begin
                instructions[load_count[ADDR_WIDTH-1:0]] <= in_data;
                load_count <= load_count + 1'b1;
            end
            if (set_ovf) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule
